// File: rtl/pc_stack_unit.sv
// PC register plus return-address LIFO; ret > jmp > branch > seq.
// Optional PC_STACK_ERR_EN: drop overflow/underflow, sticky stackErr.
module pc_stack_unit #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int OFF_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pcEn,
  input  logic                       jmp,
  input  logic                       branch,
  input  logic                       ret,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          jmpAddr,
  input  logic [OFF_W-1:0]           branchOff,
  output logic [ADDR_W-1:0]          pc,
  output logic [$clog2(DEPTH):0]     sp,
  output logic                       stackFull,
  output logic                       stackEmpty,
  output logic                       stackErr
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = IW + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] tos;
  logic [ADDR_W-1:0] pc_nxt;
  logic [IW-1:0]     top_idx;
  logic [IW-1:0]     wr_idx;
  logic [SW-1:0]     sp_nxt;
  logic              wr_en;
  logic              s_ret;
  logic              s_jmp;
  logic              s_br;

  assign stackEmpty = (sp == '0);
  assign stackFull  = (sp == SW'(DEPTH));

  // sp==DEPTH has zero low bits, so top_idx wraps to DEPTH-1
  assign top_idx = sp[IW-1:0] - IW'(1);
  assign tos     = mem[top_idx];
  assign pc_inc  = pc + ADDR_W'(1);
  assign br_tgt  = pc_inc + ADDR_W'($signed(branchOff));

  assign s_ret = ret;
  assign s_jmp = jmp & ~ret;
  assign s_br  = branch & ~ret & ~jmp;

  always_comb begin
    pc_nxt = pc_inc;
    unique case (1'b1)
      s_ret:   pc_nxt = stackEmpty ? pc_inc : tos;
      s_jmp:   pc_nxt = jmpAddr;
      s_br:    pc_nxt = br_tgt;
      default: pc_nxt = pc_inc;
    endcase
  end

  // Overflowing push writes sp[IW-1:0]==0, i.e. the oldest slot
  always_comb begin
    sp_nxt = sp;
    wr_en  = 1'b0;
    wr_idx = sp[IW-1:0];
    if (push && pop && !stackEmpty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      wr_en = 1'b1;
      if (!stackFull)
        sp_nxt = sp + SW'(1);
`ifdef PC_STACK_ERR_EN
      else
        wr_en = 1'b0;
`endif
    end else if (pop && !stackEmpty) begin
      sp_nxt = sp - SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= '0;
      sp <= '0;
    end else if (pcEn) begin
      pc <= pc_nxt;
      sp <= sp_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && pcEn && wr_en)
      mem[wr_idx] <= pc_inc;
  end

`ifdef PC_STACK_ERR_EN
  logic ovf;
  logic udf;
  logic err_q;

  assign ovf = push & ~pop & stackFull;
  assign udf = ((pop & ~push) | ret) & stackEmpty;

  always_ff @(posedge clk) begin
    if (!rst)
      err_q <= 1'b0;
    else if (pcEn && (ovf || udf))
      err_q <= 1'b1;
  end

  assign stackErr = err_q;
`else
  assign stackErr = 1'b0;
`endif

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Program-counter and return-address-stack stage sitting directly downstream of the instruction controller in the single-cycle CPU. Each enabled cycle it consumes the controller's `pcEn`, `jmp`, `branch`, `ret`, `push` and `pop` strobes and registers the next PC. That PC feeds instruction memory. The unit also holds a small LIFO of return addresses for call/return instructions and reports stack occupancy and misuse.

## Interface
Parameters:
- `ADDR_W`, 12: PC / instruction-address width.
- `DEPTH`, 8: return-stack entries; power of two, ≥2.
- `OFF_W`, 8: signed branch-offset width, ≤ ADDR_W.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on rising edge of `clk`.
- `pcEn`  in  1  controller enable; when 0, all state holds.
- `jmp`  in  1  take absolute target `jmpAddr`.
- `branch`  in  1  take PC-relative target; already condition-resolved by the controller.
- `ret`  in  1  take top-of-stack as target.
- `push`  in  1  push `pc+1` onto return stack.
- `pop`  in  1  discard top-of-stack.
- `jmpAddr`  in  ADDR_W  absolute jump/call target.
- `branchOff`  in  OFF_W  signed two's-complement branch offset.
- `pc`  out  ADDR_W  current registered PC.
- `sp`  out  $clog2(DEPTH)+1  stack occupancy, 0..DEPTH.
- `stackFull`  out  1  `sp == DEPTH`.
- `stackEmpty`  out  1  `sp == 0`.
- `stackErr`  out  1  sticky overflow/underflow flag (see Configuration).

## Operation
- `pcEn=0`: `pc`, stack contents, `sp` and `stackErr` all hold, regardless of other inputs.
- With `pcEn=1`, the next-PC source is chosen by fixed priority, `ret` > `jmp` > `branch` > sequential:
  - `ret`: `pc <= tos`. If the stack is empty, `pc <= pc+1`.
  - `jmp`: `pc <= jmpAddr`.
  - `branch`: `pc <= pc + 1 + sext(branchOff)`.
  - otherwise: `pc <= pc + 1`.
- All PC arithmetic is modulo 2^ADDR_W. Wrap from 0xFFF to 0x000 is legal and silent.
- Stack operations are independent of PC selection and are evaluated in the same cycle:
  - `push`: `mem[sp] <= pc+1`, `sp <= sp+1`. The pushed value is the current `pc+1`, never the new target.
  - `pop`: `sp <= sp-1`.
  - `push & pop` together: top entry is replaced with `pc+1`; `sp` unchanged; on an empty stack this is treated as a push.
- `tos = mem[sp-1]` is read combinationally. `ret` reads `tos` before any same-cycle pop takes effect.
- Call is `jmp & push`; return is `ret & pop`. Unpaired strobes behave exactly as listed above.
- Overflow is a push with `sp==DEPTH` (no simultaneous pop). Underflow is a pop or ret with `sp==0`. Handling depends on `PC_STACK_ERR_EN`.

## Timing
- Reset (`rst=0` at a clock edge): `pc=0`, `sp=0`, `stackErr=0`, so `stackEmpty=1` and `stackFull=0`. Stack RAM contents are not reset.
- Reset has priority over `pcEn` and every strobe, including mid-call or mid-return.
- Latency: inputs sampled at edge N produce new `pc`/`sp` visible after edge N, i.e. one cycle.
- `stackFull`, `stackEmpty` and `tos` are combinational from registered `sp`.
- No handshake: strobes are single-cycle and level-sampled only when `pcEn=1`.

## Configuration
- `PC_STACK_ERR_EN` defined:
  - Overflowing push is dropped; `sp` stays at DEPTH and contents are unchanged.
  - Underflowing pop is dropped; `sp` stays at 0.
  - Either event sets `stackErr=1`, which stays set until reset.
  - The PC update still happens: a call on a full stack still jumps.
- `PC_STACK_ERR_EN` undefined:
  - The stack is circular. An overflowing push overwrites the oldest entry at `mem[0]`, and `sp` saturates at DEPTH.
  - An underflowing pop is ignored.
  - `stackErr` is tied to 0.

## Test plan
- Reset then 3 cycles of `pcEn=1` with no strobes → `pc` = 1, 2, 3. Assert `rst=0` with `jmp=1` → `pc=0`, `sp=0`.
- `pc=0x010`, call (`jmp&push`, `jmpAddr=0x200`) → `pc=0x200`, `sp=1`, `tos=0x011`. Then return (`ret&pop`) → `pc=0x011`, `sp=0`.
- `pc=0x020`, `branch=1`: `branchOff=0xFC` → `pc=0x01D`; `branchOff=0x05` → `pc=0x023`. At `pc=0xFFF` with no strobe → `pc=0x000`.
- 9 consecutive calls with `DEPTH=8`:
  - with `PC_STACK_ERR_EN` → `sp=8`, `stackErr=1`, 9th jump still taken;
  - without it → `stackErr=0`, `mem[0]` overwritten.
- Return on an empty stack → `pc=pc+1`, `sp=0`; `stackErr=1` only with `PC_STACK_ERR_EN`.
- `pcEn=0` with `jmp=ret=push=1` → `pc`, `sp` and `stackErr` unchanged. Simultaneous `ret&jmp` with `pcEn=1` → `ret` wins.
